// File: rtl/pc_sequencer_pkg.sv
// Shared PC constants and sequencer types (the SystemVerilog home of pc.h).
package pc_sequencer_pkg;

  localparam logic [31:0] PC_START_ADDRESS = 32'h0000_3000;
  localparam logic [31:0] EXC_VECTOR_ADDR  = 32'h0000_4180;
  localparam logic        PC_ENABLED       = 1'b1;

  typedef enum logic {
    PCSEQ_RUN  = 1'b0,
    PCSEQ_HOLD = 1'b1
  } pcseq_state_e;

  // Sequential fetch address; wraps naturally at 32 bits.
  function automatic logic [31:0] seq_pc(input logic [31:0] pc);
    return pc + 32'd4;
  endfunction

endpackage

// File: rtl/pc_sequencer_if.sv
// Bundle between ID/hazard/exception logic (master) and the PC sequencer (slave).
interface pc_sequencer_if;

  logic [31:0] curr_pc;
  logic        stall;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic        jump;
  logic [31:0] jump_target;
  logic        exc_req;
  logic [31:0] exc_pc;
  logic        exc_bd;
  logic        eret;
  logic [31:0] next_pc;
  logic        pc_enable;
  logic        flush_if;
  logic [31:0] epc;
  logic        exl;

  modport master (
    output curr_pc, stall, branch_taken, branch_target, jump, jump_target,
           exc_req, exc_pc, exc_bd, eret,
    input  next_pc, pc_enable, flush_if, epc, exl
  );

  modport slave (
    input  curr_pc, stall, branch_taken, branch_target, jump, jump_target,
           exc_req, exc_pc, exc_bd, eret,
    output next_pc, pc_enable, flush_if, epc, exl
  );

endinterface

// File: rtl/pc_seq_redirect_mux.sv
// Combinational priority select of next PC, PC enable and IF flush.
// Behaviour depends on PC_SEQ_DELAY_SLOT_EN (branch delay slot: no flush on redirect).
module pc_seq_redirect_mux
  import pc_sequencer_pkg::*;
#(
  parameter logic [31:0] START_ADDR = PC_START_ADDRESS,
  parameter logic [31:0] EXC_VECTOR = EXC_VECTOR_ADDR
) (
  input  logic        rst,
  input  logic        exc_take,
  input  logic        eret,
  input  logic        hold_active,
  input  logic [31:0] hold_target,
  input  logic        jump,
  input  logic [31:0] jump_target,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  input  logic [31:0] curr_pc,
  input  logic        stall,
  input  logic [31:0] epc,
  output logic [31:0] next_pc,
  output logic        pc_enable,
  output logic        flush_if,
  output logic        redirect_new
);

`ifdef PC_SEQ_DELAY_SLOT_EN
  // The delay-slot instruction in IF must execute, so redirects never squash it.
  localparam logic REDIRECT_FLUSH = 1'b0;
`else
  localparam logic REDIRECT_FLUSH = 1'b1;
`endif

  // Priority: reset > exception > eret > held redirect > jump > branch > sequential.
  always_comb begin
    next_pc      = seq_pc(curr_pc);
    pc_enable    = !stall;
    flush_if     = 1'b0;
    redirect_new = 1'b0;
    if (rst) begin
      next_pc   = START_ADDR;
      pc_enable = PC_ENABLED;
      flush_if  = 1'b1;
    end else if (exc_take) begin
      next_pc   = EXC_VECTOR;
      pc_enable = PC_ENABLED;
      flush_if  = 1'b1;
    end else if (eret) begin
      next_pc   = epc;
      pc_enable = PC_ENABLED;
      flush_if  = 1'b1;
    end else if (hold_active) begin
      // Flush only when the held target actually loads.
      next_pc  = hold_target;
      flush_if = REDIRECT_FLUSH && !stall;
    end else if (jump) begin
      next_pc      = jump_target;
      flush_if     = REDIRECT_FLUSH && !stall;
      redirect_new = 1'b1;
    end else if (branch_taken) begin
      next_pc      = branch_target;
      flush_if     = REDIRECT_FLUSH && !stall;
      redirect_new = 1'b1;
    end
  end

endmodule

// File: rtl/pc_sequencer.sv
// Next-PC controller: holds stalled redirects and owns EPC/EXL.
// Optional feature: PC_SEQ_DELAY_SLOT_EN (branch delay slot, exc_bd honoured).
module pc_sequencer
  import pc_sequencer_pkg::*;
#(
  parameter logic [31:0] START_ADDR = PC_START_ADDRESS,
  parameter logic [31:0] EXC_VECTOR = EXC_VECTOR_ADDR
) (
  input logic           clk,
  input logic           rst,
  pc_sequencer_if.slave bus
);

  pcseq_state_e state_reg, state_next;
  logic [31:0]  hold_target_reg, hold_target_next;
  logic [31:0]  epc_reg, epc_next;
  logic         exl_reg;
  logic         exc_take;
  logic         redirect_new;
  logic [31:0]  next_pc;

  assign exc_take = bus.exc_req && !exl_reg;

`ifdef PC_SEQ_DELAY_SLOT_EN
  // A faulting delay-slot instruction restarts at its branch.
  assign epc_next = bus.exc_bd ? (bus.exc_pc - 32'd4) : bus.exc_pc;
`else
  logic unused_exc_bd;
  assign unused_exc_bd = bus.exc_bd;
  assign epc_next      = bus.exc_pc;
`endif

  pc_seq_redirect_mux #(
    .START_ADDR (START_ADDR),
    .EXC_VECTOR (EXC_VECTOR)
  ) u_mux (
    .rst           (rst),
    .exc_take      (exc_take),
    .eret          (bus.eret),
    .hold_active   (state_reg == PCSEQ_HOLD),
    .hold_target   (hold_target_reg),
    .jump          (bus.jump),
    .jump_target   (bus.jump_target),
    .branch_taken  (bus.branch_taken),
    .branch_target (bus.branch_target),
    .curr_pc       (bus.curr_pc),
    .stall         (bus.stall),
    .epc           (epc_reg),
    .next_pc       (next_pc),
    .pc_enable     (bus.pc_enable),
    .flush_if      (bus.flush_if),
    .redirect_new  (redirect_new)
  );

  assign bus.next_pc = next_pc;
  assign bus.epc     = epc_reg;
  assign bus.exl     = exl_reg;

  // Next-state logic: latch a stalled redirect, release it on the first free cycle.
  always_comb begin
    state_next       = state_reg;
    hold_target_next = hold_target_reg;
    if (exc_take || bus.eret) begin
      state_next = PCSEQ_RUN;
    end else begin
      case (state_reg)
        PCSEQ_RUN: begin
          if (redirect_new && bus.stall) begin
            state_next       = PCSEQ_HOLD;
            hold_target_next = next_pc;
          end
        end
        PCSEQ_HOLD: begin
          if (!bus.stall) state_next = PCSEQ_RUN;
        end
        default: state_next = PCSEQ_RUN;
      endcase
    end
  end

  // FSM and held-target registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg       <= PCSEQ_RUN;
      hold_target_reg <= 32'd0;
    end else begin
      state_reg       <= state_next;
      hold_target_reg <= hold_target_next;
    end
  end

  // Exception level and saved return address.
  always_ff @(posedge clk) begin
    if (rst) begin
      epc_reg <= 32'd0;
      exl_reg <= 1'b0;
    end else if (exc_take) begin
      epc_reg <= epc_next;
      exl_reg <= 1'b1;
    end else if (bus.eret) begin
      exl_reg <= 1'b0;
    end
  end

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer: vector table plus multi-cycle sequences.
module tb_pc_sequencer;

  logic clk;
  logic rst;

  pc_sequencer_if bus ();

  pc_sequencer dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

`ifdef PC_SEQ_DELAY_SLOT_EN
  localparam logic        FL_RED  = 1'b0;
  localparam logic [31:0] EPC_C   = 32'h0000_3020;
`else
  localparam logic        FL_RED  = 1'b1;
  localparam logic [31:0] EPC_C   = 32'h0000_3024;
`endif

  typedef struct {
    logic [31:0] curr_pc;
    logic        stall;
    logic        jump;
    logic [31:0] jump_target;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic [31:0] exp_next_pc;
    logic        exp_en;
    logic        exp_flush;
  } vec_t;

  vec_t vecs [6];
  int   n_pass  = 0;
  int   n_total = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got %h expected %h", name, act, exp);
    else             n_pass++;
  endtask

  task automatic idle();
    rst               = 1'b0;
    bus.curr_pc       = 32'd0;
    bus.stall         = 1'b0;
    bus.branch_taken  = 1'b0;
    bus.branch_target = 32'd0;
    bus.jump          = 1'b0;
    bus.jump_target   = 32'd0;
    bus.exc_req       = 1'b0;
    bus.exc_pc        = 32'd0;
    bus.exc_bd        = 1'b0;
    bus.eret          = 1'b0;
  endtask

  initial begin
    vecs[0] = '{32'h0000_3000, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0000_3004, 1'b1, 1'b0};
    vecs[1] = '{32'h0000_3008, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0000_300C, 1'b0, 1'b0};
    vecs[2] = '{32'h0000_3010, 1'b0, 1'b1, 32'h0000_3400, 1'b0, 32'h0, 32'h0000_3400, 1'b1, FL_RED};
    vecs[3] = '{32'h0000_3014, 1'b0, 1'b0, 32'h0, 1'b1, 32'h0000_3100, 32'h0000_3100, 1'b1, FL_RED};
    vecs[4] = '{32'h0000_3018, 1'b0, 1'b1, 32'h0000_3500, 1'b1, 32'h0000_3600, 32'h0000_3500, 1'b1, FL_RED};
    vecs[5] = '{32'hFFFF_FFFC, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0000_0000, 1'b1, 1'b0};

    // Reset for two cycles with conflicting inputs present.
    idle();
    rst             = 1'b1;
    bus.curr_pc     = 32'h0000_1234;
    bus.jump        = 1'b1;
    bus.jump_target = 32'h0000_9999;
    bus.stall       = 1'b1;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk); #1;
      $display("reset cycle %0d: next_pc=%h en=%b flush=%b", c, bus.next_pc, bus.pc_enable, bus.flush_if);
      check($sformatf("rst%0d_next_pc", c), bus.next_pc, 32'h0000_3000);
      check($sformatf("rst%0d_en", c), {31'd0, bus.pc_enable}, 32'd1);
      check($sformatf("rst%0d_flush", c), {31'd0, bus.flush_if}, 32'd1);
    end
    check("rst_epc", bus.epc, 32'd0);
    check("rst_exl", {31'd0, bus.exl}, 32'd0);

    // First cycle after release.
    @(negedge clk); idle(); bus.curr_pc = 32'h0000_3000; #1;
    $display("post-reset: next_pc=%h", bus.next_pc);
    check("post_rst_next_pc", bus.next_pc, 32'h0000_3004);
    check("post_rst_flush", {31'd0, bus.flush_if}, 32'd0);

    // Single-cycle RUN-state vectors.
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      idle();
      bus.curr_pc       = vecs[i].curr_pc;
      bus.stall         = vecs[i].stall;
      bus.jump          = vecs[i].jump;
      bus.jump_target   = vecs[i].jump_target;
      bus.branch_taken  = vecs[i].branch_taken;
      bus.branch_target = vecs[i].branch_target;
      #1;
      $display("vec %0d: curr_pc=%h next_pc=%h en=%b flush=%b", i, vecs[i].curr_pc,
               bus.next_pc, bus.pc_enable, bus.flush_if);
      check($sformatf("vec%0d_next_pc", i), bus.next_pc, vecs[i].exp_next_pc);
      check($sformatf("vec%0d_en", i), {31'd0, bus.pc_enable}, {31'd0, vecs[i].exp_en});
      check($sformatf("vec%0d_flush", i), {31'd0, bus.flush_if}, {31'd0, vecs[i].exp_flush});
    end

    // Branch during a 3-cycle stall; new redirects while held are ignored.
    @(negedge clk); idle();
    bus.curr_pc = 32'h0000_3010; bus.branch_taken = 1'b1;
    bus.branch_target = 32'h0000_3100; bus.stall = 1'b1; #1;
    $display("hold c0: en=%b", bus.pc_enable);
    check("hold_c0_en", {31'd0, bus.pc_enable}, 32'd0);
    for (int c = 1; c < 3; c++) begin
      @(negedge clk);
      bus.branch_target = 32'h0000_3999; bus.jump = 1'b1; bus.jump_target = 32'h0000_3777; #1;
      $display("hold c%0d: next_pc=%h en=%b", c, bus.next_pc, bus.pc_enable);
      check($sformatf("hold_c%0d_en", c), {31'd0, bus.pc_enable}, 32'd0);
      check($sformatf("hold_c%0d_next_pc", c), bus.next_pc, 32'h0000_3100);
    end
    @(negedge clk); idle(); bus.curr_pc = 32'h0000_3010; #1;
    $display("hold release: next_pc=%h en=%b flush=%b", bus.next_pc, bus.pc_enable, bus.flush_if);
    check("release_next_pc", bus.next_pc, 32'h0000_3100);
    check("release_en", {31'd0, bus.pc_enable}, 32'd1);
    check("release_flush", {31'd0, bus.flush_if}, {31'd0, FL_RED});
    @(negedge clk); idle(); bus.curr_pc = 32'h0000_3100; #1;
    $display("back in run: next_pc=%h", bus.next_pc);
    check("run_again_next_pc", bus.next_pc, 32'h0000_3104);
    check("run_again_flush", {31'd0, bus.flush_if}, 32'd0);

    // Exception of a delay-slot instruction under stall.
    @(negedge clk); idle();
    bus.curr_pc = 32'h0000_3028; bus.exc_req = 1'b1; bus.exc_pc = 32'h0000_3024;
    bus.exc_bd = 1'b1; bus.stall = 1'b1; bus.jump = 1'b1; bus.jump_target = 32'h0000_3400; #1;
    $display("exception: next_pc=%h en=%b flush=%b", bus.next_pc, bus.pc_enable, bus.flush_if);
    check("exc_next_pc", bus.next_pc, 32'h0000_4180);
    check("exc_en", {31'd0, bus.pc_enable}, 32'd1);
    check("exc_flush", {31'd0, bus.flush_if}, 32'd1);

    // Nested exception is ignored.
    @(negedge clk); idle();
    bus.curr_pc = 32'h0000_4180; bus.exc_req = 1'b1; bus.exc_pc = 32'h0000_5000; #1;
    $display("nested: epc=%h exl=%b next_pc=%h", bus.epc, bus.exl, bus.next_pc);
    check("exc_epc", bus.epc, EPC_C);
    check("exc_exl", {31'd0, bus.exl}, 32'd1);
    check("nested_next_pc", bus.next_pc, 32'h0000_4184);
    check("nested_flush", {31'd0, bus.flush_if}, 32'd0);

    // eret with exc_req (exl=1) and stall: eret is taken.
    @(negedge clk); idle();
    bus.curr_pc = 32'h0000_4184; bus.eret = 1'b1; bus.exc_req = 1'b1;
    bus.exc_pc = 32'h0000_5000; bus.stall = 1'b1; #1;
    $display("eret: epc=%h next_pc=%h en=%b flush=%b", bus.epc, bus.next_pc, bus.pc_enable, bus.flush_if);
    check("nested_epc_kept", bus.epc, EPC_C);
    check("eret_next_pc", bus.next_pc, EPC_C);
    check("eret_en", {31'd0, bus.pc_enable}, 32'd1);
    check("eret_flush", {31'd0, bus.flush_if}, 32'd1);
    @(negedge clk); idle(); bus.curr_pc = EPC_C; #1;
    $display("after eret: exl=%b next_pc=%h", bus.exl, bus.next_pc);
    check("eret_exl", {31'd0, bus.exl}, 32'd0);
    check("after_eret_next_pc", bus.next_pc, EPC_C + 32'd4);

    // Exception and eret together with exl=0: exception wins.
    @(negedge clk); idle();
    bus.curr_pc = 32'h0000_3204; bus.exc_req = 1'b1; bus.exc_pc = 32'h0000_3200; bus.eret = 1'b1; #1;
    $display("exc+eret: next_pc=%h", bus.next_pc);
    check("exc_eret_next_pc", bus.next_pc, 32'h0000_4180);
    @(negedge clk); idle(); bus.curr_pc = 32'h0000_4180; #1;
    $display("exc+eret after: exl=%b epc=%h", bus.exl, bus.epc);
    check("exc_eret_exl", {31'd0, bus.exl}, 32'd1);
    check("exc_eret_epc", bus.epc, 32'h0000_3200);

    // eret discards a held redirect.
    @(negedge clk); idle();
    bus.curr_pc = 32'h0000_4184; bus.jump = 1'b1; bus.jump_target = 32'h0000_4500; bus.stall = 1'b1; #1;
    check("g_hold_en", {31'd0, bus.pc_enable}, 32'd0);
    @(negedge clk); idle(); bus.curr_pc = 32'h0000_4184; bus.stall = 1'b1; bus.eret = 1'b1; #1;
    $display("eret in hold: next_pc=%h en=%b", bus.next_pc, bus.pc_enable);
    check("g_eret_next_pc", bus.next_pc, 32'h0000_3200);
    check("g_eret_en", {31'd0, bus.pc_enable}, 32'd1);
    @(negedge clk); idle(); bus.curr_pc = 32'h0000_3200; #1;
    $display("after hold discard: next_pc=%h exl=%b", bus.next_pc, bus.exl);
    check("g_discard_next_pc", bus.next_pc, 32'h0000_3204);
    check("g_exl", {31'd0, bus.exl}, 32'd0);

    // Reset while in HOLD with exl=1 clears everything.
    @(negedge clk); idle();
    bus.curr_pc = 32'h0000_3204; bus.exc_req = 1'b1; bus.exc_pc = 32'h0000_3204; #1;
    @(negedge clk); idle();
    bus.curr_pc = 32'h0000_4180; bus.branch_taken = 1'b1; bus.branch_target = 32'h0000_4800; bus.stall = 1'b1; #1;
    check("h_enter_en", {31'd0, bus.pc_enable}, 32'd0);
    check("h_exl", {31'd0, bus.exl}, 32'd1);
    @(negedge clk); idle(); bus.curr_pc = 32'h0000_4180; bus.stall = 1'b1; #1;
    $display("h held: next_pc=%h", bus.next_pc);
    check("h_held_next_pc", bus.next_pc, 32'h0000_4800);
    @(negedge clk); idle(); rst = 1'b1; bus.stall = 1'b1; bus.curr_pc = 32'h0000_4180; #1;
    $display("h reset: next_pc=%h en=%b", bus.next_pc, bus.pc_enable);
    check("h_rst_next_pc", bus.next_pc, 32'h0000_3000);
    check("h_rst_en", {31'd0, bus.pc_enable}, 32'd1);
    @(negedge clk); idle(); bus.curr_pc = 32'h0000_3000; #1;
    $display("h after reset: next_pc=%h exl=%b epc=%h", bus.next_pc, bus.exl, bus.epc);
    check("h_post_next_pc", bus.next_pc, 32'h0000_3004);
    check("h_post_flush", {31'd0, bus.flush_if}, 32'd0);
    check("h_post_exl", {31'd0, bus.exl}, 32'd0);
    check("h_post_epc", bus.epc, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
